ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter.
- Sends command bytes to the keyboard, e.g. LED update (0xED + mask) and reset (0xFF), over the same open-drain ps2_clk/ps2_dat lines the keyboard receiver listens on.
- Performs the host request sequence, shifts out data/parity/stop on device-generated clock edges, checks the device ACK, and reports completion or error.
- Asserts rx_inhibit so the receiver ignores line activity during its own transfer.

---
 rtl/ps2_host_tx_if.sv | 31 +++
 rtl/ps2_host_tx.sv | 246 ++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: groups the transmit handshake and the PS/2 line signals of
// the host-to-device transmitter.
//   tx_data/tx_valid/tx_ready : byte request handshake
//   tx_done/tx_err            : completion pulse and its status
//   rx_inhibit                : tells the receiver to ignore the lines
//   ps2_clk_in/ps2_dat_in     : raw line levels (asynchronous)
//   ps2_clk_oe/ps2_dat_oe     : 1 = pull the line low, 0 = release
// slave  : the transmitter side
// master : the requester / line side
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       rx_inhibit;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;

    modport slave (
        input  tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
        output tx_ready, tx_done, tx_err, rx_inhibit, ps2_clk_oe, ps2_dat_oe
    );

    modport master (
        output tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
        input  tx_ready, tx_done, tx_err, rx_inhibit, ps2_clk_oe, ps2_dat_oe
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Performs the request-to-send
// sequence (clock held low, then start bit), shifts data/parity/stop on
// device-generated falling clock edges, checks the device ACK and reports
// completion with an error flag.
// Ports:
//   clk28 : system clock
//   rst   : asynchronous active-high reset
//   bus   : ps2_host_tx_if.slave (handshake, status and PS/2 line signals)
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | ready for a byte, lines released
// INHIBIT   | clock held low for the request-to-send period
// RELEASE   | clock released, data held low as start bit
// SHIFT     | drive data bits 0-7 then parity on device clock falls
// STOP      | release data for the stop bit on the next fall
// ACK       | sample the device ACK on the next fall
// WAIT_IDLE | wait for both lines to return high
// FINISH    | one-cycle tx_done with tx_err
module ps2_host_tx #(
    parameter int CLK_FREQ   = 28_000_000,
    parameter int INHIBIT_US = 120,
    parameter int TIMEOUT_MS = 15,
    parameter int FILTER_LEN = 8
) (
    input  logic          clk28,
    input  logic          rst,
    ps2_host_tx_if.slave  bus
);

    localparam int INH   = CLK_FREQ / 1_000_000 * INHIBIT_US;
    localparam int TMO   = CLK_FREQ / 1000 * TIMEOUT_MS;
    localparam int INH_W = $clog2(INH + 1);
    localparam int TMO_W = $clog2(TMO + 1);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);

    // INHIBIT lasts INH-1 cycles; the RELEASE cycle still has the clock
    // held, so the clock is low for exactly INH cycles with the start bit
    // already on the data line when the clock is let go.
    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INH - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RELEASE,
        S_SHIFT,
        S_STOP,
        S_ACK,
        S_WAIT_IDLE,
        S_FINISH
    } state_t;

    state_t           state_q,    state_d;
    logic             clk_s1_q,   clk_s1_d;
    logic             clk_s2_q,   clk_s2_d;
    logic             dat_s1_q,   dat_s1_d;
    logic             dat_s2_q,   dat_s2_d;
    logic             clk_filt_q, clk_filt_d;
    logic             dat_filt_q, dat_filt_d;
    logic [FLT_W-1:0] clk_fcnt_q, clk_fcnt_d;
    logic [FLT_W-1:0] dat_fcnt_q, dat_fcnt_d;
    logic [8:0]       frame_q,    frame_d;
    logic [3:0]       bit_idx_q,  bit_idx_d;
    logic [INH_W-1:0] inh_cnt_q,  inh_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q,  tmo_cnt_d;
    logic             clk_oe_q,   clk_oe_d;
    logic             dat_oe_q,   dat_oe_d;
    logic             err_q,      err_d;
    logic             clk_fall;

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            clk_filt_q <= 1'b1;
            dat_filt_q <= 1'b1;
            clk_fcnt_q <= '0;
            dat_fcnt_q <= '0;
            frame_q    <= '0;
            bit_idx_q  <= '0;
            inh_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            dat_s1_q   <= dat_s1_d;
            dat_s2_q   <= dat_s2_d;
            clk_filt_q <= clk_filt_d;
            dat_filt_q <= dat_filt_d;
            clk_fcnt_q <= clk_fcnt_d;
            dat_fcnt_q <= dat_fcnt_d;
            frame_q    <= frame_d;
            bit_idx_q  <= bit_idx_d;
            inh_cnt_q  <= inh_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            err_q      <= err_d;
        end
    end

    // Synchronizers and glitch filters. A filter counts consecutive
    // samples that differ from the accepted level and adopts the new
    // level on the FILTER_LEN-th one.
    always_comb begin
        clk_s1_d   = bus.ps2_clk_in;
        clk_s2_d   = clk_s1_q;
        dat_s1_d   = bus.ps2_dat_in;
        dat_s2_d   = dat_s1_q;
        clk_filt_d = clk_filt_q;
        dat_filt_d = dat_filt_q;
        clk_fcnt_d = clk_fcnt_q;
        dat_fcnt_d = dat_fcnt_q;

        if (clk_s2_q == clk_filt_q) begin
            clk_fcnt_d = '0;
        end else if (clk_fcnt_q == FLT_LAST) begin
            clk_filt_d = clk_s2_q;
            clk_fcnt_d = '0;
        end else begin
            clk_fcnt_d = clk_fcnt_q + FLT_W'(1);
        end

        if (dat_s2_q == dat_filt_q) begin
            dat_fcnt_d = '0;
        end else if (dat_fcnt_q == FLT_LAST) begin
            dat_filt_d = dat_s2_q;
            dat_fcnt_d = '0;
        end else begin
            dat_fcnt_d = dat_fcnt_q + FLT_W'(1);
        end
    end

    // Fall strobe is taken from the filter update itself, so the line
    // drivers change on the same edge the filtered clock goes low.
    assign clk_fall = clk_filt_q & ~clk_filt_d;

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_idx_d = bit_idx_q;
        inh_cnt_d = inh_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        clk_oe_d  = clk_oe_q;
        dat_oe_d  = dat_oe_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (bus.tx_valid) begin
                    frame_d   = {~^bus.tx_data, bus.tx_data};
                    err_d     = 1'b0;
                    clk_oe_d  = 1'b1;
                    inh_cnt_d = INH_LOAD;
                    state_d   = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (inh_cnt_q <= INH_W'(1)) begin
                    dat_oe_d = 1'b1;
                    state_d  = S_RELEASE;
                end else begin
                    inh_cnt_d = inh_cnt_q - INH_W'(1);
                end
            end

            S_RELEASE: begin
                clk_oe_d  = 1'b0;
                bit_idx_d = '0;
                tmo_cnt_d = TMO_LOAD;
                state_d   = S_SHIFT;
            end

            S_SHIFT, S_STOP, S_ACK, S_WAIT_IDLE: begin
                // Timeout wins over a fall arriving in the same cycle.
                if (tmo_cnt_q == '0) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = S_FINISH;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
                    case (state_q)
                        S_SHIFT: begin
                            if (clk_fall) begin
                                dat_oe_d = ~frame_q[bit_idx_q];
                                if (bit_idx_q == 4'd8) begin
                                    state_d = S_STOP;
                                end else begin
                                    bit_idx_d = bit_idx_q + 4'd1;
                                end
                            end
                        end
                        S_STOP: begin
                            if (clk_fall) begin
                                dat_oe_d = 1'b0;
                                state_d  = S_ACK;
                            end
                        end
                        S_ACK: begin
                            if (clk_fall) begin
                                err_d   = dat_filt_q;
                                state_d = S_WAIT_IDLE;
                            end
                        end
                        default: begin
                            if (clk_filt_q && dat_filt_q) begin
                                state_d = S_FINISH;
                            end
                        end
                    endcase
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    assign bus.ps2_clk_oe = clk_oe_q;
    assign bus.ps2_dat_oe = dat_oe_q;
    assign bus.tx_ready   = (state_q == S_IDLE);
    assign bus.tx_done    = (state_q == S_FINISH);
    assign bus.tx_err     = err_q;
    assign bus.rx_inhibit = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx at 1 MHz: 100 us inhibit (100 cycles), 1 ms timeout
// (1000 cycles), 8-sample filter. The bench acts as the PS/2 device: it owns
// the open-drain lines (wired-AND with the DUT drivers), clocks at 12.5 kHz,
// samples bits on its rising edges and optionally ACKs.
module tb_ps2_host_tx;

    localparam int HALF    = 40;
    localparam int INH_CYC = 100;
    localparam int TMO_CYC = 1000;

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         glitch;
        bit         poke;
        bit         exp_par;
        bit         exp_err;
    } vec_t;

    logic clk28 = 1'b0;
    logic rst;
    logic dev_clk;
    logic dev_dat;
    int   n_vec = 0;
    int   n_mis = 0;
    int   done_cnt = 0;
    logic done_err = 1'b0;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .CLK_FREQ   (1_000_000),
        .INHIBIT_US (100),
        .TIMEOUT_MS (1),
        .FILTER_LEN (8)
    ) dut (
        .clk28 (clk28),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk28 = ~clk28;

    assign bus.ps2_clk_in = dev_clk & ~bus.ps2_clk_oe;
    assign bus.ps2_dat_in = dev_dat & ~bus.ps2_dat_oe;

    always @(negedge clk28) begin
        if (bus.tx_done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_err <= bus.tx_err;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk28);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One device clock: low half, rise (sample data), high half. Optional
    // 3-cycle glitch in the high half, optional ACK pull-down 20 cycles
    // before the next fall.
    task automatic dev_pulse(input bit glitch, input bit ack_low, output bit sampled);
        dev_clk = 1'b0;
        step(HALF);
        dev_clk = 1'b1;
        sampled = bus.ps2_dat_in;
        step(15);
        if (glitch) begin
            dev_clk = 1'b0;
            step(3);
            dev_clk = 1'b1;
        end else begin
            step(3);
        end
        step(2);
        if (ack_low) dev_dat = 1'b0;
        step(HALF - 20);
    endtask

    task automatic accept(input logic [7:0] d);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        step(1);
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
    endtask

    // Counts cycles with the clock held low; returns at the first cycle the
    // clock is released.
    task automatic wait_release(output int cnt);
        cnt = 0;
        while (bus.ps2_clk_oe === 1'b1 && cnt < 5000) begin
            cnt++;
            step(1);
        end
    endtask

    task automatic run_xfer(input logic [7:0] d, input bit ack, input bit glitch,
                            input bit poke, input bit exp_par, input bit exp_err);
        int         cnt;
        int         done0;
        logic [9:0] seen;
        bit         s;
        done0 = done_cnt;
        seen  = '0;
        accept(d);
        check("ready_drop", 32'(bus.tx_ready), 32'(0));
        check("inhibit_up", 32'(bus.rx_inhibit), 32'(1));
        wait_release(cnt);
        check("clk_low_len", 32'(cnt), 32'(INH_CYC));
        check("start_bit", 32'(bus.ps2_dat_in), 32'(0));
        step(20);
        if (poke) begin
            bus.tx_data  = ~d;
            bus.tx_valid = 1'b1;
            step(1);
            bus.tx_valid = 1'b0;
        end
        for (int n = 1; n <= 11; n++) begin
            dev_pulse(glitch && n == 3, ack && n == 10, s);
            if (n <= 10) seen[n-1] = s;
        end
        dev_dat = 1'b1;
        cnt = 0;
        while (done_cnt == done0 && cnt < 200) begin
            step(1);
            cnt++;
        end
        check("done_count", 32'(done_cnt - done0), 32'(1));
        check("data_bits", 32'(seen[7:0]), 32'(d));
        check("parity", 32'(seen[8]), 32'(exp_par));
        check("stop", 32'(seen[9]), 32'(1));
        check("err", 32'(done_err), 32'(exp_err));
        step(1);
        check("ready_after", 32'(bus.tx_ready), 32'(1));
        check("inhibit_after", 32'(bus.rx_inhibit), 32'(0));
        check("clk_oe_after", 32'(bus.ps2_clk_oe), 32'(0));
        check("dat_oe_after", 32'(bus.ps2_dat_oe), 32'(0));
        step(20);
    endtask

    initial begin
        vec_t       vecs[8];
        logic [7:0] d;
        bit         ack;
        bit         gl;
        int         cnt;
        int         done0;
        bit         s;

        // data, ack, glitch, poke, expected parity, expected err
        vecs[0] = '{8'hED, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        rst          = 1'b1;
        dev_clk      = 1'b1;
        dev_dat      = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        step(3);
        check("rst_clk_oe", 32'(bus.ps2_clk_oe), 32'(0));
        check("rst_dat_oe", 32'(bus.ps2_dat_oe), 32'(0));
        check("rst_ready", 32'(bus.tx_ready), 32'(1));
        check("rst_done", 32'(bus.tx_done), 32'(0));
        check("rst_err", 32'(bus.tx_err), 32'(0));
        check("rst_inhibit", 32'(bus.rx_inhibit), 32'(0));
        rst = 1'b0;
        step(20);

        for (int i = 0; i < 8; i++) begin
            run_xfer(vecs[i].data, vecs[i].ack, vecs[i].glitch, vecs[i].poke,
                     vecs[i].exp_par, vecs[i].exp_err);
        end

        // Random bytes: reference is odd parity over the byte and an error
        // exactly when the device withholds its ACK.
        for (int r = 0; r < 6; r++) begin
            d   = 8'($urandom_range(0, 255));
            ack = 1'($urandom_range(0, 1));
            gl  = 1'($urandom_range(0, 1));
            run_xfer(d, ack, gl, 1'b0, ($countones(d) % 2) == 0, !ack);
        end

        // Device never clocks: timeout counted from clock release.
        accept(8'h55);
        wait_release(cnt);
        check("tmo_clk_low_len", 32'(cnt), 32'(INH_CYC));
        cnt = 0;
        while (bus.tx_done !== 1'b1 && cnt < 3000) begin
            step(1);
            cnt++;
        end
        check("tmo_len", 32'(cnt), 32'(TMO_CYC));
        check("tmo_err", 32'(bus.tx_err), 32'(1));
        check("tmo_clk_oe", 32'(bus.ps2_clk_oe), 32'(0));
        check("tmo_dat_oe", 32'(bus.ps2_dat_oe), 32'(0));
        step(1);
        check("tmo_ready", 32'(bus.tx_ready), 32'(1));
        step(20);

        // Reset while bit 4 (a 0, so data is pulled low) is on the line.
        accept(8'h00);
        wait_release(cnt);
        step(20);
        for (int n = 1; n <= 4; n++) dev_pulse(1'b0, 1'b0, s);
        dev_clk = 1'b0;
        step(20);
        check("pre_rst_dat_oe", 32'(bus.ps2_dat_oe), 32'(1));
        done0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_clk_oe", 32'(bus.ps2_clk_oe), 32'(0));
        check("rst_mid_dat_oe", 32'(bus.ps2_dat_oe), 32'(0));
        check("rst_mid_ready", 32'(bus.tx_ready), 32'(1));
        check("rst_mid_inhibit", 32'(bus.rx_inhibit), 32'(0));
        dev_clk = 1'b1;
        step(3);
        rst = 1'b0;
        step(50);
        check("rst_mid_no_done", 32'(done_cnt - done0), 32'(0));

        run_xfer(8'h12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
